// File: rtl/miter_sweep_driver_if.sv
// rtl/miter_sweep_driver_if.sv - handshake and status bundle between the sweep driver and its environment
interface miter_sweep_driver_if #(
  parameter int N_IN = 6
);
  logic            start;
  logic [N_IN-1:0] miter_in;
  logic            miter_out;
  logic            cex_valid;
  logic            cex_ready;
  logic [N_IN-1:0] cex_data;
  logic [N_IN:0]   cex_count;
  logic            busy;
  logic            done;
  logic            found;

  modport master (
    input  start, miter_out, cex_ready,
    output miter_in, cex_valid, cex_data, cex_count, busy, done, found
  );

  modport slave (
    output start, miter_out, cex_ready,
    input  miter_in, cex_valid, cex_data, cex_count, busy, done, found
  );
endinterface

// File: rtl/miter_sweep_driver.sv
// rtl/miter_sweep_driver.sv - exhaustive miter stimulus sweep with counterexample stream
// Walks every assignment in ascending order and reports each one that drives the miter high.
module miter_sweep_driver #(
  parameter int N_IN          = 6,
  parameter int STOP_ON_FIRST = 0
) (
  input  logic clk,
  input  logic rst_n,
  miter_sweep_driver_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWEEP  = 2'd1,
    S_REPORT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0] cex_data_q, cex_data_d;
  logic [N_IN:0]   cex_count_q, cex_count_d;
  logic            cnt_last;

  assign cnt_last = &cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cex_data_q  <= '0;
      cex_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cex_data_q  <= cex_data_d;
      cex_count_q <= cex_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cex_data_d  = cex_data_q;
    cex_count_d = cex_count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          cnt_d       = '0;
          cex_count_d = '0;
          state_d     = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (bus.miter_out) begin
          cex_data_d = cnt_q;
          state_d    = S_REPORT;
        end else if (cnt_last) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + N_IN'(1);
        end
      end
      S_REPORT: begin
        // cnt stays on the failing assignment until the consumer takes it
        if (bus.cex_ready) begin
          cex_count_d = cex_count_q + (N_IN+1)'(1);
          if (STOP_ON_FIRST != 0 || cnt_last) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + N_IN'(1);
            state_d = S_SWEEP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.miter_in  = cnt_q;
  assign bus.cex_valid = (state_q == S_REPORT);
  assign bus.cex_data  = cex_data_q;
  assign bus.cex_count = cex_count_q;
  assign bus.busy      = (state_q == S_SWEEP) || (state_q == S_REPORT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.found     = (state_q == S_DONE) && (cex_count_q != '0);
endmodule

// File: tb/tb_miter_sweep_driver.sv
// tb/tb_miter_sweep_driver.sv - randomized sweep bench for miter_sweep_driver against a per-assignment timeline model
module tb_miter_sweep_driver;
  localparam int TMAX = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] tt;

  always #5 clk = ~clk;

  miter_sweep_driver_if #(.N_IN(6)) bus_a();
  miter_sweep_driver_if #(.N_IN(6)) bus_b();

  assign bus_a.miter_out = tt[bus_a.miter_in];
  assign bus_b.miter_out = tt[bus_b.miter_in];

  miter_sweep_driver #(.N_IN(6), .STOP_ON_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.master)
  );
  miter_sweep_driver #(.N_IN(6), .STOP_ON_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.master)
  );

  logic [5:0] o_mi   [2];
  logic       o_v    [2];
  logic [5:0] o_data [2];
  logic [6:0] o_cnt  [2];
  logic       o_busy [2];
  logic       o_done [2];
  logic       o_found[2];

  assign o_mi[0] = bus_a.miter_in;   assign o_mi[1] = bus_b.miter_in;
  assign o_v[0] = bus_a.cex_valid;   assign o_v[1] = bus_b.cex_valid;
  assign o_data[0] = bus_a.cex_data; assign o_data[1] = bus_b.cex_data;
  assign o_cnt[0] = bus_a.cex_count; assign o_cnt[1] = bus_b.cex_count;
  assign o_busy[0] = bus_a.busy;     assign o_busy[1] = bus_b.busy;
  assign o_done[0] = bus_a.done;     assign o_done[1] = bus_b.done;
  assign o_found[0] = bus_a.found;   assign o_found[1] = bus_b.found;

  // Expected timeline per DUT: index t is the cycle after the t-th edge following the start edge.
  logic [5:0] e_mi  [2][TMAX];
  logic       e_v   [2][TMAX];
  logic [5:0] e_data[2][TMAX];
  logic [6:0] e_cnt [2][TMAX];
  logic       e_rdy [2][TMAX];
  int         len      [2];
  logic [5:0] done_mi  [2];
  logic [5:0] done_data[2];
  logic [6:0] done_cnt [2];
  logic [5:0] last_data[2];
  int         done_t   [2];

  int vectors = 0;
  int miscompares = 0;

  task automatic build(input int k, input bit stop, input int dfix);
    int n = 0;
    int cnt = 0;
    int d;
    logic [5:0] last = last_data[k];
    bit halt = 0;
    logic [5:0] fin = 6'd63;
    for (int a = 0; a < 64 && !halt; a++) begin
      e_mi[k][n] = 6'(a); e_v[k][n] = 1'b0; e_data[k][n] = last;
      e_cnt[k][n] = 7'(cnt); e_rdy[k][n] = 1'($urandom % 2); n++;
      if (tt[a]) begin
        d = (dfix >= 0) ? dfix : int'($urandom_range(0, 3));
        for (int j = 0; j <= d; j++) begin
          e_mi[k][n] = 6'(a); e_v[k][n] = 1'b1; e_data[k][n] = 6'(a);
          e_cnt[k][n] = 7'(cnt); e_rdy[k][n] = (j == d); n++;
        end
        last = 6'(a);
        cnt++;
        if (stop) begin
          halt = 1;
          fin = 6'(a);
        end
      end
    end
    len[k] = n;
    done_mi[k] = fin;
    done_data[k] = last;
    done_cnt[k] = 7'(cnt);
    last_data[k] = last;
  endtask

  task automatic cmp(input int k, input string nm, input logic [5:0] mi, input logic v,
                     input logic [5:0] dat, input logic [6:0] c, input logic b,
                     input logic dn, input logic f);
    vectors++;
    if (o_mi[k] !== mi || o_v[k] !== v || o_data[k] !== dat || o_cnt[k] !== c ||
        o_busy[k] !== b || o_done[k] !== dn || o_found[k] !== f) begin
      miscompares++;
      $display("FAIL %s dut%0d t=%0t: got mi=%0d v=%0d data=%0d cnt=%0d busy=%0d done=%0d found=%0d; want mi=%0d v=%0d data=%0d cnt=%0d busy=%0d done=%0d found=%0d",
               nm, k, $time, o_mi[k], o_v[k], o_data[k], o_cnt[k], o_busy[k], o_done[k], o_found[k],
               mi, v, dat, c, b, dn, f);
    end
  endtask

  task automatic pin(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    for (int k = 0; k < 2; k++) cmp(k, nm, 6'd0, 1'b0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_cycle(input int t);
    for (int k = 0; k < 2; k++) begin
      if (t < len[k])
        cmp(k, "sweep", e_mi[k][t], e_v[k][t], e_data[k][t], e_cnt[k][t], 1'b1, 1'b0, 1'b0);
      else
        cmp(k, "done", done_mi[k], 1'b0, done_data[k], done_cnt[k], 1'b0, 1'b1, done_cnt[k] != 7'd0);
      if (o_done[k] === 1'b1 && done_t[k] < 0) done_t[k] = t;
    end
  endtask

  // abort_t >= 0 pulls reset low at that timeline index and ends the sweep there.
  task automatic run_sweep(input int abort_t);
    int lim = ((len[0] > len[1]) ? len[0] : len[1]) + 3;
    done_t[0] = -1;
    done_t[1] = -1;
    bus_a.start = 1'b1; bus_b.start = 1'b1;
    bus_a.cex_ready = 1'($urandom % 2); bus_b.cex_ready = 1'($urandom % 2);
    @(posedge clk); #1;
    for (int t = 0; t < lim; t++) begin
      check_cycle(t);
      if (t == abort_t) begin
        rst_n = 1'b0;
        #1;
        check_reset("abort_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset("abort_idle");
        last_data[0] = 6'd0;
        last_data[1] = 6'd0;
        bus_a.start = 1'b0; bus_b.start = 1'b0;
        return;
      end
      bus_a.start = (t < len[0]) ? 1'($urandom % 2) : 1'b0;
      bus_b.start = (t < len[1]) ? 1'($urandom % 2) : 1'b0;
      bus_a.cex_ready = (t < len[0]) ? e_rdy[0][t] : 1'($urandom % 2);
      bus_b.cex_ready = (t < len[1]) ? e_rdy[1][t] : 1'($urandom % 2);
      @(posedge clk); #1;
    end
    bus_a.start = 1'b0; bus_b.start = 1'b0;
  endtask

  task automatic prep(input int dfix);
    build(0, 1'b0, dfix);
    build(1, 1'b1, dfix);
  endtask

  initial begin
    rst_n = 1'b0;
    tt = '0;
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    bus_a.cex_ready = 1'b0; bus_b.cex_ready = 1'b0;
    last_data[0] = 6'd0; last_data[1] = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_hold");
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_reset("reset_idle");
    end

    // clean sweep
    tt = '0;
    prep(0);
    pin("model_clean_len", len[0], 64);
    run_sweep(-1);
    pin("clean_done_a", done_t[0], 64);
    pin("clean_done_b", done_t[1], 64);
    pin("clean_found_a", int'(o_found[0]), 0);

    // three hits, ready always high
    tt = '0; tt[9] = 1'b1; tt[20] = 1'b1; tt[58] = 1'b1;
    prep(0);
    pin("model_hits_len", len[0], 67);
    run_sweep(-1);
    pin("hits_done_a", done_t[0], 67);
    pin("hits_cnt_a", int'(o_cnt[0]), 3);
    pin("hits_data_a", int'(o_data[0]), 58);
    pin("stop_done_b", done_t[1], 11);
    pin("stop_cnt_b", int'(o_cnt[1]), 1);
    pin("stop_data_b", int'(o_data[1]), 9);

    // backpressure: five low-ready cycles on the hit at 9
    tt = '0; tt[9] = 1'b1;
    prep(5);
    run_sweep(-1);
    pin("bp_done_a", done_t[0], 70);
    pin("bp_done_b", done_t[1], 16);

    // only the all-ones assignment fails
    tt = '0; tt[63] = 1'b1;
    prep(0);
    run_sweep(-1);
    pin("top_done_a", done_t[0], 65);
    pin("top_done_b", done_t[1], 65);
    pin("top_mi_a", int'(o_mi[0]), 63);
    pin("top_cnt_a", int'(o_cnt[0]), 1);

    // abort during the first REPORT cycle of the hit at 5
    for (int i = 0; i < 64; i++) tt[i] = ($urandom % 6 == 0);
    tt[4:0] = 5'd0; tt[5] = 1'b1;
    prep(-1);
    run_sweep(6);

    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 64; i++) tt[i] = ($urandom % 6 == 0);
      prep(-1);
      run_sweep(-1);
      pin("rand_cnt_a", int'(o_cnt[0]), int'(done_cnt[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
